// File: rtl/definitions_pkg.sv
// Shared command encoding for the traffic_lights command port.
// CMD_NONE is the all-zero encoding presented whenever no command is valid.
package definitions_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        SET_MANUAL = 3'd1,
        SET_RED    = 3'd2,
        SET_YELLOW = 3'd3,
        SET_GREEN  = 3'd4,
        SET_ON     = 3'd5,
        SET_OFF    = 3'd6
    } command_e;

endpackage

// File: rtl/traffic_cmd_sequencer.sv
// traffic_cmd_sequencer
// Shares the command port of one traffic_lights instance between NUM_REQ
// requesters. A round-robin arbiter picks one request while idle, and the
// accepted request is expanded into the single-cycle command burst the
// light expects:
//   normal request : SET_MANUAL/0, SET_RED/red, SET_YELLOW/yellow,
//                    SET_GREEN/green, SET_ON/0
//   manual request : SET_MANUAL/0
// A request with any zero time field (and not manual) is accepted but
// rejected: err_o pulses and no command is issued.
// After each burst the block idles in HOLD for HOLDOFF_TICKS cycles.
//
// Handshake rules (request side): a requester raises req_valid_i[i] with
// stable fields and holds it until it sees req_ready_o[i]; the transfer
// happens in the cycle where valid && ready are both high. Ready is
// combinational, one-hot, and only ever asserted in IDLE. The command side
// has no backpressure: every command is presented for exactly one cycle
// with cmd_valid_o high.
module traffic_cmd_sequencer
    import definitions_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int DATA_W        = 16,
    parameter int HOLDOFF_TICKS = 4,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                            clk_2k_i,
    input  logic                            srst_n_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0]              req_manual_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_red_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_yellow_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_green_i,
    output logic                            cmd_valid_o,
    output command_e                        cmd_type_o,
    output logic [DATA_W-1:0]               cmd_data_o,
    output logic                            busy_o,
    output logic [ID_W-1:0]                 grant_id_o,
    output logic                            err_o,
    output logic [2:0]                      dbg_state_o
);

    // FSM encoding; each burst state is the cycle in which that command is
    // being presented on the command port.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] S_MAN = 3'd1;
    localparam logic [2:0] S_RED = 3'd2;
    localparam logic [2:0] S_YEL = 3'd3;
    localparam logic [2:0] S_GRN = 3'd4;
    localparam logic [2:0] S_ON  = 3'd5;
    localparam logic [2:0] HOLD  = 3'd6;

    // Holdoff counter counts down from HOLDOFF_TICKS-1 to 0 inside HOLD.
    localparam int HOLD_W = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT =
        HOLD_W'((HOLDOFF_TICKS > 0) ? (HOLDOFF_TICKS - 1) : 0);

    logic [2:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [HOLD_W-1:0]  hold_cnt;

    logic               lat_manual;
    logic [DATA_W-1:0]  lat_red;
    logic [DATA_W-1:0]  lat_yellow;
    logic [DATA_W-1:0]  lat_green;

    logic               cmd_valid_q;
    command_e           cmd_type_q;
    logic [DATA_W-1:0]  cmd_data_q;
    logic [ID_W-1:0]    grant_id_q;
    logic               err_q;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    next_ptr;
    logic               handshake;
    logic               reject;

    // Requester index base+off, wrapped into 0..NUM_REQ-1.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = (32'(base) + off) % 32'(NUM_REQ);
        return sum[ID_W-1:0];
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid_i[wrap_idx(rr_ptr, 32'(i))]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(rr_ptr, 32'(i));
            end
        end
    end

    // Ready, handshake and rejection decode for the current winner.
    always_comb begin
        handshake   = (state == IDLE) && win_found;
        req_ready_o = handshake ? (NUM_REQ'(1) << win_idx) : '0;
        next_ptr    = wrap_idx(win_idx, 32'd1);
        reject      = !req_manual_i[win_idx] &&
                      ((req_red_i[win_idx]    == '0) ||
                       (req_yellow_i[win_idx] == '0) ||
                       (req_green_i[win_idx]  == '0));
    end

    // Sequencer FSM with registered command, grant and error outputs.
    always_ff @(posedge clk_2k_i) begin
        if (!srst_n_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            lat_manual  <= 1'b0;
            lat_red     <= '0;
            lat_yellow  <= '0;
            lat_green   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_NONE;
            cmd_data_q  <= '0;
            grant_id_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            // Commands and errors are single-cycle; default back to idle values.
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_NONE;
            cmd_data_q  <= '0;

            case (state)
                IDLE: begin
                    if (handshake) begin
                        grant_id_q <= win_idx;
                        rr_ptr     <= next_ptr;
                        lat_manual <= req_manual_i[win_idx];
                        lat_red    <= req_red_i[win_idx];
                        lat_yellow <= req_yellow_i[win_idx];
                        lat_green  <= req_green_i[win_idx];
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            cmd_valid_q <= 1'b1;
                            cmd_type_q  <= SET_MANUAL;
                            cmd_data_q  <= '0;
                            state       <= S_MAN;
                        end
                    end
                end

                S_MAN: begin
                    if (lat_manual) begin
                        if (HOLDOFF_TICKS == 0) begin
                            state <= IDLE;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_INIT;
                        end
                    end else begin
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= SET_RED;
                        cmd_data_q  <= lat_red;
                        state       <= S_RED;
                    end
                end

                S_RED: begin
                    cmd_valid_q <= 1'b1;
                    cmd_type_q  <= SET_YELLOW;
                    cmd_data_q  <= lat_yellow;
                    state       <= S_YEL;
                end

                S_YEL: begin
                    cmd_valid_q <= 1'b1;
                    cmd_type_q  <= SET_GREEN;
                    cmd_data_q  <= lat_green;
                    state       <= S_GRN;
                end

                S_GRN: begin
                    cmd_valid_q <= 1'b1;
                    cmd_type_q  <= SET_ON;
                    cmd_data_q  <= '0;
                    state       <= S_ON;
                end

                S_ON: begin
                    if (HOLDOFF_TICKS == 0) begin
                        state <= IDLE;
                    end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_INIT;
                    end
                end

                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered outputs and state-derived status.
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign grant_id_o  = grant_id_q;
    assign err_o       = err_q;
    assign busy_o      = (state != IDLE);
    assign dbg_state_o = state;

endmodule

// File: tb/tb_traffic_cmd_sequencer.sv
// Bench for traffic_cmd_sequencer: directed scenarios followed by random
// traffic. A transaction-level model predicts grants, errors, command bursts
// and busy windows into expected queues; a negedge monitor compares the DUT
// against those queues every cycle.
module tb_traffic_cmd_sequencer;
    import definitions_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 16;
    localparam int H       = 4;
    localparam int ID_W    = 1;

    typedef struct packed {
        logic              manual;
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] g;
    } req_t;

    // ---------------- clock / reset / DUT ----------------
    logic clk_2k = 1'b0;
    always #5 clk_2k = ~clk_2k;

    logic                           srst_n;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_manual;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_red;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_yellow;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_green;
    logic                           cmd_valid;
    command_e                       cmd_type;
    logic [DATA_W-1:0]              cmd_data;
    logic                           busy;
    logic [ID_W-1:0]                grant_id;
    logic                           err;
    logic [2:0]                     dbg_state;

    traffic_cmd_sequencer #(
        .NUM_REQ       (NUM_REQ),
        .DATA_W        (DATA_W),
        .HOLDOFF_TICKS (H)
    ) dut (
        .clk_2k_i     (clk_2k),
        .srst_n_i     (srst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_manual_i (req_manual),
        .req_red_i    (req_red),
        .req_yellow_i (req_yellow),
        .req_green_i  (req_green),
        .cmd_valid_o  (cmd_valid),
        .cmd_type_o   (cmd_type),
        .cmd_data_o   (cmd_data),
        .busy_o       (busy),
        .grant_id_o   (grant_id),
        .err_o        (err),
        .dbg_state_o  (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk_2k) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // Entry layout: {cycle[31:0], id[7:0], type[7:0], data[15:0]}
    logic [63:0] ready_q[$];
    logic [63:0] err_q[$];
    logic [63:0] cmd_q[$];
    logic [63:0] grant_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    logic [ID_W-1:0] exp_gid = '0;

    function automatic logic [63:0] ent(int c, int id, int t, logic [15:0] d);
        return {32'(c), 8'(id), 8'(t), d};
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h (dbg_state=%0d)",
                     name, cyc, act, exp, dbg_state);
        end
    endfunction

    // ---------------- reference model ----------------
    bit   pend_v[NUM_REQ];
    req_t pend_d[NUM_REQ];
    int   rr_m     = 0;
    int   free_at  = 0;   // earliest cycle a new handshake may occur
    int   bus_from = 0;
    int   bus_to   = -1;
    int   n_grants = 0;

    // Decide this cycle's grant from pending requests and queue its effects.
    task automatic model_arb();
        bit   found;
        int   w;
        req_t d;
        found = 1'b0;
        w     = 0;
        if (cyc >= free_at) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && pend_v[(rr_m + k) % NUM_REQ]) begin
                    found = 1'b1;
                    w     = (rr_m + k) % NUM_REQ;
                end
            end
        end
        if (found) begin
            d         = pend_d[w];
            pend_v[w] = 1'b0;
            rr_m      = (w + 1) % NUM_REQ;
            n_grants++;
            ready_q.push_back(ent(cyc, w, 0, 16'd0));
            grant_q.push_back(ent(cyc + 1, w, 0, 16'd0));
            if (!d.manual && (d.r == 0 || d.y == 0 || d.g == 0)) begin
                err_q.push_back(ent(cyc + 1, w, 0, 16'd0));
                free_at = cyc + 1;
            end else if (d.manual) begin
                cmd_q.push_back(ent(cyc + 1, w, int'(SET_MANUAL), 16'd0));
                free_at  = cyc + 2 + H;
                bus_from = cyc + 1;
                bus_to   = free_at - 1;
            end else begin
                cmd_q.push_back(ent(cyc + 1, w, int'(SET_MANUAL), 16'd0));
                cmd_q.push_back(ent(cyc + 2, w, int'(SET_RED),    d.r));
                cmd_q.push_back(ent(cyc + 3, w, int'(SET_YELLOW), d.y));
                cmd_q.push_back(ent(cyc + 4, w, int'(SET_GREEN),  d.g));
                cmd_q.push_back(ent(cyc + 5, w, int'(SET_ON),     16'd0));
                free_at  = cyc + 6 + H;
                bus_from = cyc + 1;
                bus_to   = free_at - 1;
            end
        end
    endtask

    // Reset took effect at the start of the current cycle: forget the burst.
    task automatic model_reset();
        while (cmd_q.size() > 0 && int'(cmd_q[$][63:32]) >= cyc) void'(cmd_q.pop_back());
        while (err_q.size() > 0 && int'(err_q[$][63:32]) >= cyc) void'(err_q.pop_back());
        while (grant_q.size() > 0 && int'(grant_q[$][63:32]) >= cyc) void'(grant_q.pop_back());
        grant_q.push_back(ent(cyc, 0, 0, 16'd0));
        rr_m    = 0;
        free_at = cyc;
        bus_to  = cyc - 1;
        for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic post(int i, logic m, logic [15:0] r, logic [15:0] y, logic [15:0] g);
        pend_v[i] = 1'b1;
        pend_d[i] = '{manual: m, r: r, y: y, g: g};
    endtask

    task automatic post_rand(int i, bit allow_zero);
        logic        m;
        logic [15:0] r, y, g;
        int          z;
        m = ($urandom_range(0, 4) == 0);
        r = 16'($urandom_range(1, 60));
        y = 16'($urandom_range(1, 60));
        g = 16'($urandom_range(1, 60));
        if (allow_zero && $urandom_range(0, 5) == 0) begin
            z = $urandom_range(0, 2);
            if (z == 0) r = '0;
            else if (z == 1) y = '0;
            else g = '0;
        end
        post(i, m, r, y, g);
    endtask

    // Pending requesters hold valid with stable fields; idle ones drive junk
    // fields so any late sampling of the inputs shows up in the data.
    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_v[i]) begin
                req_valid[i]  = 1'b1;
                req_manual[i] = pend_d[i].manual;
                req_red[i]    = pend_d[i].r;
                req_yellow[i] = pend_d[i].y;
                req_green[i]  = pend_d[i].g;
            end else begin
                req_valid[i]  = 1'b0;
                req_manual[i] = 1'($urandom);
                req_red[i]    = 16'($urandom);
                req_yellow[i] = 16'($urandom);
                req_green[i]  = 16'($urandom);
            end
        end
    endtask

    // One clock cycle: drive, predict, advance.
    task automatic step();
        bit rst_now;
        drive_inputs();
        rst_now = !srst_n;
        if (!rst_now) model_arb();
        @(posedge clk_2k);
        #1;
        if (rst_now) begin
            model_reset();
            srst_n = 1'b1;
        end
    endtask

    task automatic run_idle();
        int g;
        g = 0;
        while ((pend_v[0] || pend_v[1] || cyc <= free_at) && g < 300) begin
            step();
            g++;
        end
        if (g >= 300) chk("idle_timeout", 64'(g), 64'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_2k) begin : monitor
        logic [63:0]        e;
        logic [NUM_REQ-1:0] exp_rdy;
        logic               exp_err;
        logic [19:0]        exp_cmd;
        if (mon_en) begin
            exp_rdy = '0;
            if (ready_q.size() > 0 && int'(ready_q[0][63:32]) == cyc) begin
                e       = ready_q.pop_front();
                exp_rdy = NUM_REQ'(1) << e[31:24];
            end
            chk("ready", 64'(req_ready), 64'(exp_rdy));

            exp_err = 1'b0;
            if (err_q.size() > 0 && int'(err_q[0][63:32]) == cyc) begin
                void'(err_q.pop_front());
                exp_err = 1'b1;
            end
            chk("err", 64'(err), 64'(exp_err));

            exp_cmd = '0;
            if (cmd_q.size() > 0 && int'(cmd_q[0][63:32]) == cyc) begin
                e       = cmd_q.pop_front();
                exp_cmd = {1'b1, e[18:16], e[15:0]};
            end
            chk("cmd", 64'({cmd_valid, cmd_type, cmd_data}), 64'(exp_cmd));

            if (grant_q.size() > 0 && int'(grant_q[0][63:32]) == cyc) begin
                e       = grant_q.pop_front();
                exp_gid = e[24 +: ID_W];
            end
            chk("grant_id", 64'(grant_id), 64'(exp_gid));

            chk("busy", 64'(busy), 64'((cyc >= bus_from) && (cyc <= bus_to)));
        end
    end

    // ---------------- test sequence ----------------
    initial begin : stimulus
        int g0;
        int guard;
        srst_n     = 1'b0;
        req_valid  = '0;
        req_manual = '0;
        req_red    = '0;
        req_yellow = '0;
        req_green  = '0;
        for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;

        // Reset values
        repeat (3) @(posedge clk_2k);
        @(negedge clk_2k);
        chk("rst_ready",     64'(req_ready), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_type",  64'(cmd_type),  64'd0);
        chk("rst_cmd_data",  64'(cmd_data),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_grant_id",  64'(grant_id),  64'd0);
        chk("rst_err",       64'(err),       64'd0);
        @(posedge clk_2k);
        #1;
        srst_n  = 1'b1;
        free_at = cyc;
        mon_en  = 1'b1;

        // Single request
        post(0, 1'b0, 16'd10, 16'd5, 16'd20);
        run_idle();

        // Contention: both held valid for four bursts
        g0    = n_grants;
        guard = 0;
        while (n_grants < g0 + 4 && guard < 200) begin
            if (!pend_v[0]) post_rand(0, 1'b0);
            if (!pend_v[1]) post_rand(1, 1'b0);
            step();
            guard++;
        end
        run_idle();

        // Manual-only request
        post(1, 1'b1, 16'd0, 16'd0, 16'd0);
        run_idle();

        // Zero time field rejected, other requester served next cycle
        post(0, 1'b0, 16'd10, 16'd5, 16'd0);
        post(1, 1'b0, 16'd7, 16'd8, 16'd9);
        run_idle();

        // Reset during the S_YEL cycle, then a fresh contended request
        post(0, 1'b0, 16'd11, 16'd12, 16'd13);
        step();
        step();
        step();
        srst_n = 1'b0;
        step();
        post(1, 1'b0, 16'd21, 16'd22, 16'd23);
        post(0, 1'b0, 16'd31, 16'd32, 16'd33);
        run_idle();

        // Random traffic
        repeat (600) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) == 0) post_rand(i, 1'b1);
            end
            step();
        end
        run_idle();
        repeat (3) step();

        chk("drain_ready", 64'(ready_q.size()), 64'd0);
        chk("drain_err",   64'(err_q.size()),   64'd0);
        chk("drain_cmd",   64'(cmd_q.size()),   64'd0);
        chk("drain_grant", 64'(grant_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
